cla_pipe: RTL and testbench
===========================

// Module: cla_pipe
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 16-bit combinational CLA.
//  Splits a WIDTH-bit operation into 16-bit blocks, one block per pipeline stage. Carry ripples stage-to-stage through registers.
//  Provides valid/ready handshake, tag pass-through and a full flag set (C, V, Z, N). Sits between the EX operand mux and writeback.
// PARAMETERS
//  WIDTH   32  operand/result width; multiple of 16, range 16..64
//  TAG_W   4   width of opaque tag carried alongside each op
// PORTS
//  clk_i        in   1       single clock, rising edge
//  rst_ni       in   1       asynchronous, active-low reset
//  in_valid_i   in   1       operation presented
//  in_ready_o   out  1       pipeline accepts op this cycle
//  a_i          in   WIDTH   operand A
//  b_i          in   WIDTH   operand B
//  sub_i        in   1       0: B+A; 1: B-A (A inverted, carry-in 1)
//  sat_i        in   1       request signed saturation (see CONFIGURATION)
//  tag_i        in   TAG_W   opaque tag
//  out_valid_o  out  1       result valid
//  out_ready_i  in   1       consumer accepts result
//  result_o     out  WIDTH   sum/difference
//  flags_o      out  4       {N,Z,V,C}, indices from cla_pkg
//  tag_o        out  TAG_W   tag of result_o
// BEHAVIOUR
//  - NBLK = WIDTH/16 stages; latency = NBLK cycles from accept to out_valid_o, when not stalled. Throughput is 1 op/cycle.
//  - Stage k computes bits [16k+15:16k] from the registered carry of stage k-1; stage 0 uses carry-in = sub_i.
//    Unconsumed upper operand slices, tag and sub/sat are skewed forward with their op.
//  - Global stall: adv = !out_valid_o | out_ready_i. All stage registers load only when adv=1. in_ready_o = adv.
//  - Accept = in_valid_i & in_ready_o. A bubble is inserted when in_valid_i=0 and adv=1.
//  - Outputs are held stable while out_valid_o=1 & out_ready_i=0.
//  - C = carry out of MSB. For subtract, C=1 means no borrow (B>=A unsigned).
//  - V = carry into MSB ^ carry out of MSB.
//  - N = result_o[WIDTH-1]. Z = 1 iff result_o==0; accumulated per stage as an AND of block-zero terms.
//  - Reset (async, any time incl. mid-operation): all valid bits, data, tag and flags regs are cleared to 0.
//    out_valid_o=0 immediately; in_ready_o=1 after deassert. In-flight ops are discarded, never emitted.
//  - No X propagation: data regs of bubble stages are don't-care internally, but result_o/flags_o/tag_o read 0 until the first valid result.
// CONFIGURATION
//  CLA_PIPE_SAT_EN defined:
//    - if sat_i & V: result_o = 0x7F..F when the true result is positive, 0x80..0 when negative.
//    - V stays 1; N and Z recomputed from the clamped value; C unchanged.
//  CLA_PIPE_SAT_EN undefined: sat_i ignored (port kept), result wraps modulo 2^WIDTH.
// STRUCTURE
//  cla_pkg: BLK_W=16, GRP_W=4, FLAG_C=0, FLAG_V=1, FLAG_Z=2, FLAG_N=3, typedef flags_t (4-bit).
//  Sub-module cla_blk16: combinational 16-bit block (4x 4-bit groups + lookahead unit),
//    inputs p/g/cin, outputs sum, cout, carry into bit 15 (for V).
//  Instantiated NBLK times via generate. Stage registers live in cla_pipe.
// TESTING (WIDTH=32, latency 2)
//  1 add A=0x0000_0001 B=0xFFFF_FFFF -> result 0x0000_0000, C=1 Z=1 V=0 N=0, valid 2 cycles after accept
//  2 sub A=0x0000_0001 B=0x0000_0000 -> 0xFFFF_FFFF, C=0 N=1 V=0 Z=0; sub A=5 B=5 -> 0, C=1 Z=1
//  3 cross-block carry: add A=0x0000_FFFF B=0x0000_0001 -> 0x0001_0000, C=0 Z=0
//  4 overflow: add A=0x7FFF_FFFF B=1 sat_i=1 -> 0x8000_0000 V=1 N=1 (no macro);
//      0x7FFF_FFFF V=1 N=0 (CLA_PIPE_SAT_EN)
//  5 backpressure: 4 back-to-back ops tags 1..4, out_ready_i=0 for 3 cycles after first valid ->
//      in_ready_o=0 during stall, outputs held, all 4 emitted in order, none lost or duplicated
//  6 reset mid-op: rst_ni low with 2 ops in flight -> out_valid_o=0 same cycle;
//      after release no result emitted until a new accept

Source files
------------

// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants for the pipelined carry-lookahead adder/subtractor.
//   BLK_W   : bits resolved per pipeline stage (one cla_blk16 per stage)
//   GRP_W   : bits per lookahead group inside a block
//   FLAG_*  : bit positions inside flags_o ({N,Z,V,C})
//   flags_t : 4-bit flag vector type
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int BLK_W  = 16;
    localparam int GRP_W  = 4;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/cla_blk16.sv
// -----------------------------------------------------------------------------
// cla_blk16
// Combinational 16-bit carry-lookahead block: four 4-bit groups whose
// group generate/propagate terms feed a second-level lookahead unit.
// Ports:
//   i_p    : bitwise propagate (a ^ b)
//   i_g    : bitwise generate  (a & b)
//   i_cin  : carry into bit 0
//   o_sum  : 16-bit sum
//   o_cout : carry out of bit 15
//   o_c15  : carry into bit 15 (used for signed overflow)
// -----------------------------------------------------------------------------
module cla_blk16
    import cla_pkg::*;
(
    input  logic [BLK_W-1:0] i_p,
    input  logic [BLK_W-1:0] i_g,
    input  logic             i_cin,
    output logic [BLK_W-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c15
);

    localparam int NGRP = BLK_W / GRP_W;

    logic [NGRP-1:0] w_gp;
    logic [NGRP-1:0] w_gg;
    logic [NGRP:0]   w_gc;
    logic [BLK_W:0]  w_c;

    // group propagate / generate
    always_comb begin : group_pg
        logic v_gg;
        w_gp = '0;
        w_gg = '0;
        for (int j = 0; j < NGRP; j++) begin
            w_gp[j] = &i_p[j*GRP_W +: GRP_W];
            v_gg    = 1'b0;
            for (int b = 0; b < GRP_W; b++) begin
                v_gg = i_g[j*GRP_W+b] | (i_p[j*GRP_W+b] & v_gg);
            end
            w_gg[j] = v_gg;
        end
    end

    // second-level lookahead: every group carry depends only on cin and
    // group terms, so no carry ripples between groups
    assign w_gc[0] = i_cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

    // bit carries inside each group, seeded by the lookahead group carry
    always_comb begin : bit_carry
        w_c = '0;
        for (int j = 0; j < NGRP; j++) begin
            w_c[j*GRP_W] = w_gc[j];
            for (int b = 0; b < GRP_W-1; b++) begin
                w_c[j*GRP_W+b+1] = i_g[j*GRP_W+b] | (i_p[j*GRP_W+b] & w_c[j*GRP_W+b]);
            end
        end
        w_c[BLK_W] = w_gc[NGRP];
    end

    assign o_sum  = i_p ^ w_c[BLK_W-1:0];
    assign o_cout = w_c[BLK_W];
    assign o_c15  = w_c[BLK_W-1];

endmodule

// File: rtl/cla_pipe.sv
// -----------------------------------------------------------------------------
// cla_pipe
// Pipelined WIDTH-bit carry-lookahead adder/subtractor, one 16-bit block per
// stage, carry passed stage-to-stage through registers. Global stall with a
// valid/ready handshake; tag and flags travel with each op.
// Optional feature macro: CLA_PIPE_SAT_EN (signed saturation on sat_i & V).
// Ports:
//   clk_i, rst_ni             : clock, async active-low reset
//   in_valid_i / in_ready_o   : input handshake
//   a_i, b_i, sub_i, sat_i    : operands; sub_i=1 gives B-A
//   tag_i                     : opaque tag
//   out_valid_o / out_ready_i : output handshake
//   result_o, flags_o, tag_o  : result, {N,Z,V,C}, tag of result
// -----------------------------------------------------------------------------
module cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
)(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             sat_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output flags_t           flags_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int NBLK = WIDTH / BLK_W;

    logic             w_adv;

    logic [NBLK-1:0]  r_vld;
    logic [WIDTH-1:0] r_a   [NBLK];
    logic [WIDTH-1:0] r_b   [NBLK];
    logic [WIDTH-1:0] r_sum [NBLK];
    logic             r_cy  [NBLK];
    logic             r_zr  [NBLK];
    logic             r_sat [NBLK];
    logic [TAG_W-1:0] r_tag [NBLK];
    flags_t           r_flags;

    logic [WIDTH-1:0] w_a_in    [NBLK];
    logic [WIDTH-1:0] w_b_in    [NBLK];
    logic [WIDTH-1:0] w_sum_in  [NBLK];
    logic [WIDTH-1:0] w_sum_nxt [NBLK];
    logic [TAG_W-1:0] w_tag_in  [NBLK];
    logic             w_c15     [NBLK];
    logic [NBLK-1:0]  w_vld_in;
    logic [NBLK-1:0]  w_cin;
    logic [NBLK-1:0]  w_zr_in;
    logic [NBLK-1:0]  w_zr_nxt;
    logic [NBLK-1:0]  w_sat_in;
    logic [NBLK-1:0]  w_cout;

    logic [WIDTH-1:0] w_res_fin;
    logic             w_zf;
    logic             w_v;
    flags_t           w_flags_fin;

    assign w_adv      = ~r_vld[NBLK-1] | out_ready_i;
    assign in_ready_o = w_adv;

    genvar k;
    generate
        for (k = 0; k < NBLK; k++) begin : g_stage
            localparam logic [WIDTH-1:0] L_MASK = WIDTH'({BLK_W{1'b1}}) << (k*BLK_W);
            logic [BLK_W-1:0] w_blk_sum;

            if (k == 0) begin : g_first
                // stage 0 takes operands straight from the ports; subtract is
                // folded in here as ~A with carry-in 1
                assign w_a_in[k]   = sub_i ? ~a_i : a_i;
                assign w_b_in[k]   = b_i;
                assign w_sum_in[k] = '0;
                assign w_cin[k]    = sub_i;
                assign w_zr_in[k]  = 1'b1;
                assign w_vld_in[k] = in_valid_i;
                assign w_tag_in[k] = tag_i;
                assign w_sat_in[k] = sat_i;
            end else begin : g_next
                // stage k consumes the registered state of stage k-1
                assign w_a_in[k]   = r_a[k-1];
                assign w_b_in[k]   = r_b[k-1];
                assign w_sum_in[k] = r_sum[k-1];
                assign w_cin[k]    = r_cy[k-1];
                assign w_zr_in[k]  = r_zr[k-1];
                assign w_vld_in[k] = r_vld[k-1];
                assign w_tag_in[k] = r_tag[k-1];
                assign w_sat_in[k] = r_sat[k-1];
            end

            cla_blk16 u_blk (
                .i_p    (w_a_in[k][k*BLK_W +: BLK_W] ^ w_b_in[k][k*BLK_W +: BLK_W]),
                .i_g    (w_a_in[k][k*BLK_W +: BLK_W] & w_b_in[k][k*BLK_W +: BLK_W]),
                .i_cin  (w_cin[k]),
                .o_sum  (w_blk_sum),
                .o_cout (w_cout[k]),
                .o_c15  (w_c15[k])
            );

            assign w_sum_nxt[k] = (w_sum_in[k] & ~L_MASK) | (WIDTH'(w_blk_sum) << (k*BLK_W));
            assign w_zr_nxt[k]  = w_zr_in[k] & (w_blk_sum == '0);
        end
    endgenerate

`ifdef CLA_PIPE_SAT_EN
    // wrapped MSB set on overflow means the true result was positive
    function automatic logic [WIDTH-1:0] sat_clamp(input logic wrapped_msb);
        return wrapped_msb ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    endfunction
`endif

    assign w_v = w_c15[NBLK-1] ^ w_cout[NBLK-1];

    // final stage: flag assembly and optional clamp
    always_comb begin
        w_res_fin = w_sum_nxt[NBLK-1];
        w_zf      = w_zr_nxt[NBLK-1];
`ifdef CLA_PIPE_SAT_EN
        if (w_sat_in[NBLK-1] & w_v) begin
            w_res_fin = sat_clamp(w_sum_nxt[NBLK-1][WIDTH-1]);
            w_zf      = (w_res_fin == '0);
        end
`endif
        w_flags_fin         = '0;
        w_flags_fin[FLAG_C] = w_cout[NBLK-1];
        w_flags_fin[FLAG_V] = w_v;
        w_flags_fin[FLAG_Z] = w_zf;
        w_flags_fin[FLAG_N] = w_res_fin[WIDTH-1];
    end

`ifndef CLA_PIPE_SAT_EN
    logic w_unused_sat;
    assign w_unused_sat = w_sat_in[NBLK-1];
`endif

    // stage registers: valid bits move on every advance, data only with a
    // valid op so outputs stay 0 until the first real result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld   <= '0;
            r_flags <= '0;
            for (int s = 0; s < NBLK; s++) begin
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_sum[s] <= '0;
                r_cy[s]  <= 1'b0;
                r_zr[s]  <= 1'b0;
                r_sat[s] <= 1'b0;
                r_tag[s] <= '0;
            end
        end else if (w_adv) begin
            for (int s = 0; s < NBLK; s++) begin
                r_vld[s] <= w_vld_in[s];
                if (w_vld_in[s]) begin
                    r_a[s]   <= w_a_in[s];
                    r_b[s]   <= w_b_in[s];
                    r_sum[s] <= (s == NBLK-1) ? w_res_fin : w_sum_nxt[s];
                    r_cy[s]  <= w_cout[s];
                    r_zr[s]  <= w_zr_nxt[s];
                    r_sat[s] <= w_sat_in[s];
                    r_tag[s] <= w_tag_in[s];
                end
            end
            if (w_vld_in[NBLK-1]) begin
                r_flags <= w_flags_fin;
            end
        end
    end

    assign out_valid_o = r_vld[NBLK-1];
    assign result_o    = r_sum[NBLK-1];
    assign tag_o       = r_tag[NBLK-1];
    assign flags_o     = r_flags;

endmodule

// File: tb/tb_cla_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe
// Scoreboard bench for cla_pipe (WIDTH=32): the driver pushes the expected
// result of every accepted op, a monitor pops and compares on each handshake.
// -----------------------------------------------------------------------------
module tb_cla_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             sub_i = 1'b0;
    logic             sat_i = 1'b0;
    logic [TAG_W-1:0] tag_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [WIDTH-1:0] result_o;
    logic [3:0]       flags_o;
    logic [TAG_W-1:0] tag_o;

    always #5 clk = ~clk;

    cla_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .sub_i       (sub_i),
        .sat_i       (sat_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .flags_o     (flags_o),
        .tag_o       (tag_o)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [3:0]       flg;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: 3-cycle stall on first valid
    int   stall_left = 3;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sub, input logic sat,
                                  output logic [WIDTH-1:0] r, output logic [3:0] f);
        longint sa, sb, t;
        logic [63:0] ua, ub;
        logic c, v, z, n;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        t  = sub ? (sb - sa) : (sb + sa);
        r  = t[WIDTH-1:0];
        c  = sub ? (ub >= ua) : (((ua + ub) >> WIDTH) != 0);
        v  = (t != longint'($signed(r)));
`ifdef CLA_PIPE_SAT_EN
        if (sat && v) r = (t > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
        if (sat) r = r;
`endif
        z = (r == 0);
        n = r[WIDTH-1];
        f = {n, z, v, c};
    endfunction

    // out_ready driver, single writer of out_ready_i
    always @(negedge clk) begin
        if (rdy_mode == 1) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
        end else if (rdy_mode == 2 && out_valid_o && stall_left > 0) begin
            out_ready_i = 1'b0;
            stall_left--;
        end else begin
            out_ready_i = 1'b1;
        end
        if (rdy_mode != 2) stall_left = 3;
    end

    // monitor: pop and compare on every output handshake, check hold on stall
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] h_res;
    logic [3:0]       h_flg;
    logic [TAG_W-1:0] h_tag;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_ni) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_valid_o, 1'b1);
                    check("hold_result", result_o, h_res);
                    check("hold_flags", flags_o, h_flg);
                    check("hold_tag", tag_o, h_tag);
                end
                if (out_valid_o && !out_ready_i) check("in_ready_stall", in_ready_o, 1'b0);
                if (out_valid_o && out_ready_i) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: got result %0h tag %0h, required none", result_o, tag_o);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", result_o, e.res);
                        check("flags", flags_o, e.flg);
                        check("tag", tag_o, e.tag);
                    end
                end
                prev_stall = out_valid_o && !out_ready_i;
                h_res = result_o;
                h_flg = flags_o;
                h_tag = tag_o;
            end
        end
    end

    // present one op until accepted; expected value from model or given constants
    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic sat, input logic [TAG_W-1:0] tag,
                         input bit use_exp, input logic [WIDTH-1:0] er, input logic [3:0] ef);
        exp_t e;
        bit   done;
        done = 0;
        e.tag = tag;
        if (use_exp) begin
            e.res = er;
            e.flg = ef;
        end else begin
            model(a, b, sub, sat, e.res, e.flg);
        end
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            in_valid_i = 1'b1;
            a_i = a; b_i = b; sub_i = sub; sat_i = sat; tag_i = tag;
            #1;
            if (in_ready_o) begin
                sb_q.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready_o stayed 0, required 1 within 200 cycles");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) idle();
        repeat (2) idle();
        check("drain_empty", sb_q.size(), 0);
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit found;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_result", result_o, 32'h0);
        check("rst_flags", flags_o, 4'h0);
        check("rst_tag", tag_o, 4'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check("rst_in_ready", in_ready_o, 1'b1);

        // 1: add wrapping to zero, latency 2
        drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd1, 1, 32'h0000_0000, 4'b0101);
        lat = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            in_valid_i = 1'b0;
            #1;
            lat++;
            if (out_valid_o) found = 1;
        end
        check("latency", lat, 2);

        // 2: subtracts
        drive(32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 4'd2, 1, 32'hFFFF_FFFF, 4'b1000);
        drive(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 4'd3, 1, 32'h0000_0000, 4'b0101);
        // 3: carry across the block boundary
        drive(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd4, 1, 32'h0001_0000, 4'b0000);
        // 4: signed overflow with saturation request
`ifdef CLA_PIPE_SAT_EN
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 4'd5, 1, 32'h7FFF_FFFF, 4'b0010);
`else
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 4'd5, 1, 32'h8000_0000, 4'b1010);
`endif
        drain();

        // 5: backpressure, 4 back-to-back ops
        rdy_mode = 2;
        for (int i = 1; i <= 4; i++) begin
            drive($urandom, $urandom, i[0], 1'b0, TAG_W'(i), 0, '0, '0);
        end
        drain();
        rdy_mode = 0;

        // randomized traffic with bubbles and random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                drive(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      TAG_W'($urandom), 0, '0, '0);
            end
        end
        rdy_mode = 0;
        drain();

        // 6: reset with two ops in flight
        drive(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 4'd6, 0, '0, '0);
        drive(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 4'd7, 0, '0, '0);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("midrst_out_valid", out_valid_o, 1'b0);
        check("midrst_result", result_o, 32'h0);
        check("midrst_tag", tag_o, 4'h0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("postrst_no_valid", out_valid_o, 1'b0);
            check("postrst_in_ready", in_ready_o, 1'b1);
        end

        // pipeline usable again after reset
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 4'd8, 1, 32'h0000_0002, 4'b0000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
